// File: rtl/alu_muldiv_sequencer.sv
// Iterative RV32M MUL/DIV/DIVU/REM/REMU sequencer that borrows the shared EX-stage ALU.
// Passes EX operands through to the ALU while idle; owns it (ADD/SUB only) while an M-op runs.
module alu_muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic [3:0]  ex_alu_op,
  input  logic        md_valid,
  input  logic [2:0]  md_funct3,
  input  logic        md_kill,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_c,
  output logic [31:0] md_result,
  output logic        md_done,
  output logic        md_illegal,
  output logic        md_stall
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRE_A = 3'd1;
  localparam logic [2:0] PRE_B = 3'd2;
  localparam logic [2:0] ITER  = 3'd3;
  localparam logic [2:0] POST  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd9;

  logic [2:0]  state;
  logic [2:0]  f3;
  logic        neg_a, neg_b, ill;
  logic [4:0]  cnt;
  // opx: multiplicand / dividend-then-quotient; opy: multiplier / divisor; acc: product / remainder
  logic [31:0] opx, opy, acc;

  logic        is_div, is_rem, is_uns;
  logic        in_div, in_uns, in_rem, in_ill, in_dz, in_ovf, accept;
  logic [31:0] r_sh, rem_nx, quo_nx, acc_mul, post_src;
  logic        borrow, ge, post_neg;

  assign is_div = f3[2];
  assign is_rem = f3[1];
  assign is_uns = f3[0];

  assign in_div = md_funct3[2];
  assign in_rem = md_funct3[1];
  assign in_uns = md_funct3[0];
  assign in_ill = ~md_funct3[2] & (md_funct3[1] | md_funct3[0]);
  assign in_dz  = in_div & (ex_b == 32'd0);
  assign in_ovf = in_div & ~in_uns & (ex_a == 32'h8000_0000) & (ex_b == 32'hFFFF_FFFF);
  assign accept = (state == IDLE) & md_valid & ~md_kill;

  // Restoring step: acc[31] is the 33rd bit of the shifted partial remainder.
  assign r_sh     = {acc[30:0], opx[31]};
  assign borrow   = (~r_sh[31] & opy[31]) | (~(r_sh[31] ^ opy[31]) & alu_c[31]);
  assign ge       = acc[31] | ~borrow;
  assign rem_nx   = ge ? alu_c : r_sh;
  assign quo_nx   = {opx[30:0], ge};
  assign acc_mul  = opy[0] ? alu_c : acc;
  assign post_neg = is_rem ? neg_a : (neg_a ^ neg_b);
  assign post_src = is_rem ? acc : opx;

  always_comb begin
    alu_a  = ex_a;
    alu_b  = ex_b;
    alu_op = ex_alu_op;
    case (state)
      PRE_A: begin alu_a = 32'd0; alu_b = opx; alu_op = OP_SUB; end
      PRE_B: begin alu_a = 32'd0; alu_b = opy; alu_op = OP_SUB; end
      ITER: begin
        if (is_div) begin alu_a = r_sh; alu_b = opy; alu_op = OP_SUB; end
        else        begin alu_a = acc;  alu_b = opx; alu_op = OP_ADD; end
      end
      POST:    begin alu_a = 32'd0; alu_b = post_src; alu_op = OP_SUB; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      f3        <= 3'd0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      ill       <= 1'b0;
      cnt       <= 5'd0;
      opx       <= 32'd0;
      opy       <= 32'd0;
      acc       <= 32'd0;
      md_result <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            f3    <= md_funct3;
            opx   <= ex_a;
            opy   <= ex_b;
            acc   <= 32'd0;
            cnt   <= 5'd0;
            neg_a <= in_div & ~in_uns & ex_a[31];
            neg_b <= in_div & ~in_uns & ex_b[31];
            ill   <= in_ill;
            if (in_ill) begin
              md_result <= 32'd0;
              state     <= DONE;
            end else if (in_dz) begin
              md_result <= in_rem ? ex_a : 32'hFFFF_FFFF;
              state     <= DONE;
            end else if (in_ovf) begin
              md_result <= in_rem ? 32'd0 : 32'h8000_0000;
              state     <= DONE;
            end else if (in_div & ~in_uns) begin
              state <= PRE_A;
            end else begin
              state <= ITER;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          ill   <= 1'b0;
        end
        default: begin
          if (md_kill) begin
            state <= IDLE;
          end else begin
            case (state)
              PRE_A: begin
                if (neg_a) opx <= alu_c;
                state <= PRE_B;
              end
              PRE_B: begin
                if (neg_b) opy <= alu_c;
                state <= ITER;
              end
              ITER: begin
                cnt <= cnt + 5'd1;
                if (is_div) begin
                  acc <= rem_nx;
                  opx <= quo_nx;
                end else begin
                  acc <= acc_mul;
                  opx <= {opx[30:0], 1'b0};
                  opy <= {1'b0, opy[31:1]};
                end
                if (cnt == 5'd31) begin
                  if (is_div & ~is_uns) begin
                    state <= POST;
                  end else begin
                    md_result <= is_div ? (is_rem ? rem_nx : quo_nx) : acc_mul;
                    state     <= DONE;
                  end
                end
              end
              POST: begin
                md_result <= post_neg ? alu_c : post_src;
                state     <= DONE;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign md_done    = (state == DONE);
  assign md_illegal = md_done & ill;
  assign md_stall   = md_valid & ~md_done & ~rst;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Bench for alu_muldiv_sequencer: shared-ALU model plus arithmetic reference for RV32M results and latency.
module tb_alu_muldiv_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] ex_a, ex_b;
  logic [3:0]  ex_alu_op;
  logic        md_valid;
  logic [2:0]  md_funct3;
  logic        md_kill;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_c;
  logic [31:0] md_result;
  logic        md_done, md_illegal, md_stall;

  int checks;
  int failures;

  alu_muldiv_sequencer dut (
    .clk(clk), .rst(rst),
    .ex_a(ex_a), .ex_b(ex_b), .ex_alu_op(ex_alu_op),
    .md_valid(md_valid), .md_funct3(md_funct3), .md_kill(md_kill),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .md_result(md_result), .md_done(md_done), .md_illegal(md_illegal), .md_stall(md_stall)
  );

  // Shared ALU: ADD and SUB matter to the sequencer, anything else is just a distinct function.
  assign alu_c = (alu_op == 4'd0) ? alu_a + alu_b :
                 (alu_op == 4'd9) ? alu_a - alu_b : (alu_a ^ alu_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<1000000", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic ref_ill(input logic [2:0] f3);
    return (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd3);
  endfunction

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    int  sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: return a * b;
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        return 32'(sa % sb);
      end
      3'd7: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    if (ref_ill(f3)) return 1;
    if (f3 != 3'd0 && b == 32'd0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (f3 == 3'd4 || f3 == 3'd6) return 36;
    return 33;
  endfunction

  // Presents an M-op and waits for md_done; returns in the done cycle with md_valid still high.
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                          output int lat, output logic [31:0] res, output logic ill,
                          output int stall, output bit badop);
    ex_a = a; ex_b = b; md_funct3 = f3; md_valid = 1'b1; md_kill = 1'b0; ex_alu_op = 4'd5;
    lat = 0; stall = 0; badop = 1'b0; res = 32'd0; ill = 1'b0;
    for (int n = 1; n <= 80 && lat == 0; n++) begin
      #1;
      if (md_stall) stall++;
      @(posedge clk);
      #1;
      if (md_done) begin
        lat = n; res = md_result; ill = md_illegal;
      end else if (alu_op != 4'd0 && alu_op != 4'd9) begin
        badop = 1'b1;
      end
    end
  endtask

  task automatic idle_gap();
    md_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; md_valid = 1'b1; md_kill = 1'b1; md_funct3 = 3'd0;
    ex_a = 32'd5; ex_b = 32'd3; ex_alu_op = 4'd9;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (md_result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h expected 00000000", md_result); end
    checks++; if (md_done !== 1'b0 || md_illegal !== 1'b0) begin failures++; $display("FAIL reset_done: got done=%b ill=%b expected 0 0", md_done, md_illegal); end
    checks++; if (md_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", md_stall); end
    rst = 1'b0; md_valid = 1'b0; md_kill = 1'b0;
    #1;
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 4'd9) begin
      failures++; $display("FAIL reset_passthru: got a=%h b=%h op=%0d expected 5 3 9", alu_a, alu_b, alu_op);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul();
    int lat, stall; logic [31:0] res; logic ill; bit badop;
    drive_op(32'd7, 32'hFFFF_FFFD, 3'd0, lat, res, ill, stall, badop);
    checks++; if (res !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result: got %h expected ffffffeb", res); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    checks++; if (stall !== 33) begin failures++; $display("FAIL mul_stall: got %0d cycles expected 33", stall); end
    checks++; if (badop !== 1'b0) begin failures++; $display("FAIL mul_aluop: got non ADD/SUB opcode while busy, expected ADD/SUB only"); end
    idle_gap();
    checks++; if (md_done !== 1'b0) begin failures++; $display("FAIL mul_done_pulse: got %b expected 0", md_done); end
  endtask

  task automatic test_divide();
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic [2:0]  tf [6];
    logic [31:0] te [6];
    int lat, stall; logic [31:0] res; logic ill; bit badop;
    ta = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100,       32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
    tb = '{32'd2,         32'd2,         32'hFFFF_FFF9, 32'h10,        32'h10,        32'h8000_0000};
    tf = '{3'd4,          3'd6,          3'd4,          3'd5,          3'd7,          3'd5};
    te = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 32'h0FFF_FFFF, 32'hF,         32'd1};
    for (int i = 0; i < 6; i++) begin
      drive_op(ta[i], tb[i], tf[i], lat, res, ill, stall, badop);
      checks++; if (res !== te[i] || ill !== 1'b0) begin
        failures++; $display("FAIL div_result[%0d]: got %h ill=%b expected %h ill=0", i, res, ill, te[i]);
      end
      checks++; if (lat !== ((tf[i] == 3'd4 || tf[i] == 3'd6) ? 36 : 33)) begin
        failures++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lat, (tf[i] == 3'd4 || tf[i] == 3'd6) ? 36 : 33);
      end
      checks++; if (badop !== 1'b0) begin failures++; $display("FAIL div_aluop[%0d]: got non ADD/SUB opcode expected ADD/SUB only", i); end
      idle_gap();
    end
  endtask

  task automatic test_fast_path();
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [2:0]  tf [5];
    logic [31:0] te [5];
    logic        ti [5];
    int lat, stall; logic [31:0] res; logic ill; bit badop;
    ta = '{32'd5,  32'd5,  32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
    tb = '{32'd0,  32'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
    tf = '{3'd5,   3'd6,   3'd4,          3'd6,          3'd1};
    te = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
    ti = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive_op(ta[i], tb[i], tf[i], lat, res, ill, stall, badop);
      checks++; if (res !== te[i] || ill !== ti[i] || lat !== 1) begin
        failures++; $display("FAIL fast[%0d]: got res=%h ill=%b lat=%0d expected res=%h ill=%b lat=1", i, res, ill, lat, te[i], ti[i]);
      end
      idle_gap();
      checks++; if (md_done !== 1'b0 || md_illegal !== 1'b0) begin
        failures++; $display("FAIL fast_pulse[%0d]: got done=%b ill=%b expected 0 0", i, md_done, md_illegal);
      end
    end
  endtask

  task automatic test_kill();
    int lat, stall; logic [31:0] res; logic ill; bit badop; bit seen;
    drive_op(32'hFFFF_FFFF, 32'h10, 3'd5, lat, res, ill, stall, badop);
    idle_gap();
    // Kill sampled in IDLE must block the accept.
    md_valid = 1'b1; md_kill = 1'b1; md_funct3 = 3'd0; ex_a = 32'hABCD; ex_b = 32'h77; ex_alu_op = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (alu_op !== 4'd5 || alu_a !== 32'hABCD || md_done !== 1'b0) begin
      failures++; $display("FAIL kill_idle: got op=%0d a=%h done=%b expected 5 0000abcd 0", alu_op, alu_a, md_done);
    end
    md_kill = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    md_kill = 1'b1;
    @(posedge clk);
    #1;
    md_kill = 1'b0; md_valid = 1'b0;
    checks++; if (md_done !== 1'b0 || md_result !== ref_res(32'hFFFF_FFFF, 32'h10, 3'd5)) begin
      failures++; $display("FAIL kill_iter: got done=%b res=%h expected 0 %h", md_done, md_result, ref_res(32'hFFFF_FFFF, 32'h10, 3'd5));
    end
    ex_a = $urandom; ex_b = $urandom; ex_alu_op = 4'd3;
    #1;
    checks++; if (alu_a !== ex_a || alu_b !== ex_b || alu_op !== 4'd3) begin
      failures++; $display("FAIL kill_passthru: got a=%h b=%h op=%0d expected %h %h 3", alu_a, alu_b, alu_op, ex_a, ex_b);
    end
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (md_done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL kill_no_done: got md_done after kill, expected none"); end
    drive_op(32'd9, 32'd3, 3'd5, lat, res, ill, stall, badop);
    checks++; if (res !== 32'd3 || lat !== 33) begin
      failures++; $display("FAIL kill_then_divu: got res=%h lat=%0d expected 00000003 33", res, lat);
    end
    idle_gap();
  endtask

  task automatic test_rst_mid();
    drive_op_start(32'hDEAD_BEEF, 32'h1234, 3'd7);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (md_result !== 32'd0 || md_done !== 1'b0 || md_illegal !== 1'b0 || md_stall !== 1'b0) begin
      failures++; $display("FAIL rst_mid: got res=%h done=%b ill=%b stall=%b expected 0 0 0 0", md_result, md_done, md_illegal, md_stall);
    end
    rst = 1'b0; md_valid = 1'b0; ex_alu_op = 4'd9; ex_a = 32'd5; ex_b = 32'd3;
    #1;
    checks++; if (alu_op !== 4'd9 || alu_a !== 32'd5 || alu_b !== 32'd3) begin
      failures++; $display("FAIL rst_passthru: got op=%0d a=%h b=%h expected 9 5 3", alu_op, alu_a, alu_b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op_start(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    ex_a = a; ex_b = b; md_funct3 = f3; md_valid = 1'b1; md_kill = 1'b0; ex_alu_op = 4'd5;
  endtask

  task automatic test_back_to_back();
    int lat, stall; logic [31:0] res; logic ill; bit badop;
    logic [31:0] a, b; logic [2:0] f3;
    drive_op(32'h10000, 32'h10000, 3'd0, lat, res, ill, stall, badop);
    checks++; if (res !== 32'd0 || lat !== 33) begin
      failures++; $display("FAIL b2b_first: got res=%h lat=%0d expected 00000000 33", res, lat);
    end
    // Each follow-on op is presented during the DONE cycle, so it is accepted one edge later.
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom_range(1, 1000);
      f3 = (i == 0) ? 3'd0 : (i == 1) ? 3'd4 : 3'd7;
      drive_op(a, b, f3, lat, res, ill, stall, badop);
      checks++; if (res !== ref_res(a, b, f3) || lat !== ref_lat(a, b, f3) + 1) begin
        failures++; $display("FAIL b2b[%0d]: got res=%h lat=%0d expected %h %0d", i, res, lat, ref_res(a, b, f3), ref_lat(a, b, f3) + 1);
      end
    end
    idle_gap();
  endtask

  task automatic test_random();
    int lat, stall; logic [31:0] res; logic ill; bit badop;
    logic [31:0] a, b; logic [2:0] f3;
    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = {1'b1, 31'($urandom)};
        default: ;
      endcase
      drive_op(a, b, f3, lat, res, ill, stall, badop);
      checks++; if (res !== ref_res(a, b, f3) || ill !== ref_ill(f3)) begin
        failures++; $display("FAIL rand_result[%0d] f3=%0d a=%h b=%h: got %h ill=%b expected %h ill=%b", i, f3, a, b, res, ill, ref_res(a, b, f3), ref_ill(f3));
      end
      checks++; if (lat !== ref_lat(a, b, f3) || badop !== 1'b0) begin
        failures++; $display("FAIL rand_timing[%0d] f3=%0d: got lat=%0d badop=%b expected lat=%0d badop=0", i, f3, lat, badop, ref_lat(a, b, f3));
      end
      idle_gap();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; md_valid = 1'b0; md_kill = 1'b0; md_funct3 = 3'd0;
    ex_a = 32'd0; ex_b = 32'd0; ex_alu_op = 4'd0;
    test_reset();
    test_mul();
    test_divide();
    test_fast_path();
    test_kill();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
